nibble_serial_adder_ctrl: RTL

//   Sequencer that adds two WIDTH-bit operands using one shared RCA4 slice.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 13 +
 rtl/nibble_serial_adder_ctrl_if.sv | 48 ++++
 rtl/nibble_serial_adder_ctrl_rca4.sv | 23 ++
 rtl/nibble_serial_adder_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional subtract mode is enabled with NSA_SUB_EN.
package nibble_serial_adder_ctrl_pkg;

  localparam int NSA_SLICE = 4;

  typedef enum logic [1:0] {
    NSA_IDLE = 2'd0,
    NSA_RUN  = 2'd1,
    NSA_DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// op_sub exists only when NSA_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NSA_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef NSA_SUB_EN
  modport master (
    output in_valid, a, b, cin, op_sub,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, op_sub,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );
`endif

endinterface

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// Four-bit ripple-carry adder slice.
// Shared by the nibble-serial sequencer.
module rca4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) |
                      (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder, LSB nibble first, one RCA4 slice.
// Define NSA_SUB_EN to add the op_sub (a - b) mode.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int NIB = WIDTH / NSA_SLICE;
  localparam int CW  = $clog2(NIB + 1);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  localparam int TOP = WIDTH - NSA_SLICE;

  nsa_state_t       r_state;
  nsa_state_t       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       w_s;
  logic             w_co;

  rca4 u_rca4 (
    .A    (r_a[3:0]),
    .B    (r_b[3:0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      NSA_IDLE: if (bus.in_valid)  w_next = NSA_RUN;
      NSA_RUN:  if (r_cnt == LAST) w_next = NSA_DONE;
      NSA_DONE: if (bus.out_ready) w_next = NSA_IDLE;
      default:                     w_next = NSA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= NSA_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == NSA_IDLE && bus.in_valid) begin
        r_a   <= bus.a;
        r_cnt <= '0;
`ifdef NSA_SUB_EN
        r_b     <= bus.op_sub ? ~bus.b : bus.b;
        r_carry <= bus.op_sub ? 1'b1 : bus.cin;
`else
        r_b     <= bus.b;
        r_carry <= bus.cin;
`endif
      end else if (r_state == NSA_RUN) begin
        r_a     <= r_a >> NSA_SLICE;
        r_b     <= r_b >> NSA_SLICE;
        // new nibble enters at the top; after NIB steps it sits in place
        r_res   <= (r_res >> NSA_SLICE) |
                   (WIDTH'(w_s) << TOP);
        r_carry <= w_co;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == NSA_IDLE);
  assign bus.out_valid = (r_state == NSA_DONE);
  assign bus.busy      = (r_state != NSA_IDLE);
  assign bus.sum       = r_res;
  assign bus.cout      = r_carry;

endmodule
